// File: rtl/onchip_mem_tester_pkg.sv
// Shared types and the data-pattern generator for the on-chip RAM tester.
package onchip_mem_tester_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0] PAT_CONST     = 2'd0;
  localparam logic [1:0] PAT_INC       = 2'd1;
  localparam logic [1:0] PAT_XOR       = 2'd2;
  localparam logic [1:0] PAT_CONST_ALT = 2'd3;

  // Word value for 0-based index within the run at the given word address.
  function automatic logic [31:0] pattern(input logic [1:0]  mode,
                                          input logic [31:0] seed,
                                          input logic [31:0] index,
                                          input logic [31:0] address);
    case (mode)
      PAT_INC:                 return seed + index;
      PAT_XOR:                 return seed ^ address;
      PAT_CONST, PAT_CONST_ALT: return seed;
      default:                 return seed;
    endcase
  endfunction

endpackage

// File: rtl/onchip_mem_tester_if.sv
// Avalon-MM link between the tester (master) and the single-port on-chip RAM.
interface onchip_mem_tester_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;
  logic [31:0]       readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_mem_tester_rdpipe.sv
// Fixed-latency shift pipe tracking outstanding reads; the last stage lines
// up with the slave's readdata and acts as the compare strobe.
module onchip_mem_tester_rdpipe #(
  parameter int ADDR_W       = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [31:0]       push_exp,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_exp,
  output logic              empty
);
  logic [READ_LATENCY-1:0] valid_q;
  logic [ADDR_W-1:0]       addr_q [READ_LATENCY];
  logic [31:0]             exp_q  [READ_LATENCY];

  // Shift entries one stage per cycle; stage 0 takes the read on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= push_valid;
      addr_q[0]  <= push_addr;
      exp_q[0]   <= push_exp;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
        exp_q[i]   <= exp_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[READ_LATENCY-1];
  assign out_addr  = addr_q[READ_LATENCY-1];
  assign out_exp   = exp_q[READ_LATENCY-1];
  assign empty     = ~|valid_q;

endmodule

// File: rtl/onchip_mem_tester.sv
// Avalon-MM memory tester: writes a pattern over a word range, reads it back
// through a fixed-latency compare pipe and reports mismatches.
module onchip_mem_tester
  import onchip_mem_tester_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DEPTH        = 7500,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [ADDR_W:0]    cfg_len,
  input  logic [1:0]         cfg_mode,
  input  logic [31:0]        cfg_seed,
  onchip_mem_tester_if.master m,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [ADDR_W-1:0]  first_err_addr,
  output logic               range_err,
  output logic               aborted
);
  state_e            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [1:0]        mode_q;
  logic [31:0]       seed_q;

  logic [ADDR_W:0]   idx_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   range_end;
  logic              push_valid;
  logic [31:0]       push_exp;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [31:0]       cmp_exp;
  logic              pipe_empty;
  logic              mismatch;

  assign m.byteenable = 4'hF;
  assign m.clken      = 1'b1;

  // Next-access arithmetic, read tracking and compare decode.
  always_comb begin
    idx_nxt    = idx + (ADDR_W+1)'(1);
    addr_nxt   = m.address + ADDR_W'(1);
    range_end  = {1'b0, cfg_base} + cfg_len;
    push_valid = m.chipselect & ~m.write;
    push_exp   = pattern(mode_q, seed_q, 32'(idx), 32'(m.address));
    mismatch   = cmp_valid && (m.readdata != cmp_exp);
  end

  onchip_mem_tester_rdpipe #(
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rdpipe (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_addr  (m.address),
    .push_exp   (push_exp),
    .out_valid  (cmp_valid),
    .out_addr   (cmp_addr),
    .out_exp    (cmp_exp),
    .empty      (pipe_empty)
  );

  // Control FSM; bus outputs are registered one cycle ahead of each access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      base_q         <= '0;
      len_q          <= '0;
      idx            <= '0;
      mode_q         <= '0;
      seed_q         <= '0;
      m.address      <= '0;
      m.chipselect   <= 1'b0;
      m.write        <= 1'b0;
      m.writedata    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      range_err      <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      done <= 1'b0;

      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        if (err_count == '0) first_err_addr <= cmp_addr;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q         <= cfg_base;
            len_q          <= cfg_len;
            mode_q         <= cfg_mode;
            seed_q         <= cfg_seed;
            err_count      <= '0;
            first_err_addr <= '0;
            range_err      <= 1'b0;
            aborted        <= 1'b0;
            pass           <= 1'b0;
            idx            <= '0;
            if (range_end > (ADDR_W+1)'(DEPTH)) begin
              range_err <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else if (cfg_len == '0) begin
              pass  <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy         <= 1'b1;
              m.chipselect <= 1'b1;
              m.write      <= 1'b1;
              m.address    <= cfg_base;
              m.writedata  <= pattern(cfg_mode, cfg_seed, 32'd0, 32'(cfg_base));
              state        <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (abort) begin
            m.chipselect <= 1'b0;
            m.write      <= 1'b0;
            aborted      <= 1'b1;
            state        <= S_DRAIN;
          end else if (idx == len_q - (ADDR_W+1)'(1)) begin
            m.write   <= 1'b0;
            m.address <= base_q;
            idx       <= '0;
            state     <= S_READ;
          end else begin
            idx         <= idx_nxt;
            m.address   <= addr_nxt;
            m.writedata <= pattern(mode_q, seed_q, 32'(idx_nxt), 32'(addr_nxt));
          end
        end

        S_READ: begin
          if (abort) begin
            m.chipselect <= 1'b0;
            aborted      <= 1'b1;
            state        <= S_DRAIN;
          end else if (idx == len_q - (ADDR_W+1)'(1)) begin
            m.chipselect <= 1'b0;
            state        <= S_DRAIN;
          end else begin
            idx       <= idx_nxt;
            m.address <= addr_nxt;
          end
        end

        S_DRAIN: begin
          if (pipe_empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !range_err && !aborted;
            state <= S_DONE;
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/onchip_mem_tester.md
Name: onchip_mem_tester

Overview:
- Avalon-MM master (initiator) that drives the 32-bit single-port on-chip RAM slave: fills a word range with a generated pattern, then reads it back and compares.
- Used for memory bring-up and a power-on self test before the Nios core starts.
- Connects to the RAM slave's address/byteenable/chipselect/write/writedata/readdata/clken signals.
- The RAM slave has no waitrequest, so this block is a fixed-read-latency master.

Parameters:
- ADDR_W, 13, word-address width of the slave.
- DEPTH, 7500, number of valid words in the slave.
- READ_LATENCY, 1, cycles from read address presented to readdata valid; legal range 1..4.
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- abort  in  1  stop issuing accesses, drain, then finish.
- cfg_base  in  ADDR_W  first word address.
- cfg_len  in  ADDR_W+1  number of words.
- cfg_mode  in  2  pattern: 0 = constant, 1 = incrementing, 2 = address-XOR, 3 = constant.
- cfg_seed  in  32  pattern seed.
- m_address  out  ADDR_W  word address to the slave.
- m_byteenable  out  4  always 4'hF.
- m_chipselect  out  1  access strobe.
- m_write  out  1  write qualifier.
- m_writedata  out  32  write data.
- m_clken  out  1  slave clock enable; constant 1.
- m_readdata  in  32  slave read data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- pass  out  1  sticky result: err_count==0 and no range_err and no aborted.
- err_count  out  ERR_W  mismatches, saturating at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- range_err  out  1  sticky; cfg_base+cfg_len > DEPTH.
- aborted  out  1  sticky; run ended by abort.

Behaviour:
- Reset value of every output is 0, except m_byteenable = 4'hF and m_clken = 1. FSM returns to IDLE; the read pipeline is cleared.
- Reset mid-run: the access in progress is dropped and there is no done pulse.
- Pattern for index i (0-based):
  - mode 0/3: seed
  - mode 1: seed + i, modulo 2^32
  - mode 2: seed ^ zero-extended address
- States are IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - On start, latch the cfg_* inputs and clear all sticky result outputs.
  - If base+len > DEPTH (computed at ADDR_W+1 bits), set range_err and go to DONE with no bus access.
  - Else if len==0, go to DONE.
  - Else go to WRITE.
- WRITE:
  - One write per cycle: m_chipselect=1, m_write=1, address = base+i, data = pattern(i).
  - After index len-1, go to READ with i=0.
- READ:
  - One read per cycle: m_chipselect=1, m_write=0.
  - Push {valid, address, expected} into a READ_LATENCY-deep shift pipe.
  - After index len-1, go to DRAIN.
- DRAIN: wait until the pipe is empty, then go to DONE.
- Compare: when a pipe entry exits, compare m_readdata with its expected value on that cycle.
  - On mismatch, increment err_count (saturating).
  - On the first mismatch only, capture first_err_addr.
- DONE:
  - Assert done for 1 cycle, drive pass, go to IDLE.
  - busy is high in WRITE/READ/DRAIN and low in IDLE/DONE.
- Throughput: accesses are back-to-back with no bubbles. Total run = 2*len + READ_LATENCY + 2 cycles from start to done.
- abort:
  - In WRITE or READ: no further accesses; go to DRAIN and set aborted. In-flight reads are still compared.
  - In IDLE/DONE: ignored.
- start while busy is ignored. start and abort in the same IDLE cycle: start wins.
- Address never exceeds DEPTH-1, so no wrap is possible after the range check.

Decomposition:
- Package onchip_mem_tester_pkg holds:
  - FSM state enum
  - pattern mode constants
  - pattern function (mode, seed, index, address)
- Sub-module onchip_mem_tester_rdpipe: parameterised READ_LATENCY shift pipe carrying valid/address/expected and emitting the compare strobe.

Test Plan:
- base=0, len=16, mode=1, seed=32'h1000 against a model RAM with latency 1 -> 16 writes of 0x1000..0x100F, 16 reads, done at cycle 35, pass=1, err_count=0.
- Same run with model RAM forcing bit0 stuck at 1 at addr 5 and addr 9, mode=0, seed=0 -> err_count=2, first_err_addr=5, pass=0.
- base=7490, len=20 -> range_err=1, zero chipselect cycles, done 1 cycle after DONE entry, pass=0.
- len=0 -> no accesses, done pulse, pass=1; start pulsed again while busy in a len=100 run -> ignored, only one done.
- abort asserted on the 3rd READ cycle, len=10, READ_LATENCY=2 -> exactly 3 reads issued, 3 compares, aborted=1, pass=0.
- reset asserted in WRITE at index 4 -> next cycle all outputs at reset values, no done. Subsequent start with mode=2, seed=32'hA5A5A5A5 -> pass=1.
